button_event_decoder: RTL and testbench

//   Turns the debounced switch level from the switch debouncer into discrete

---
 rtl/button_event_decoder.sv | 100 ++++++++++
 tb/tb_button_event_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns a debounced switch level into press, release, click, long-press and auto-repeat pulses.
// Every event output is a registered single-cycle pulse; o_Held is a registered level.
module button_event_decoder #(
  parameter int unsigned LONG_LIMIT    = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Click,
  output logic o_Long,
  output logic o_Repeat,
  output logic o_Held
);

  localparam int unsigned MaxCount = (LONG_LIMIT > REPEAT_PERIOD) ? LONG_LIMIT : REPEAT_PERIOD;
  localparam int unsigned CntW     = $clog2(MaxCount);
  localparam logic [CntW-1:0] LongLast   = CntW'(LONG_LIMIT - 1);
  localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_e;

  state_e          state_q;
  logic            prev_q;
  logic [CntW-1:0] count_q;
  logic            press_q, release_q, click_q, long_q, repeat_q, held_q;
  logic            rise, fall;

  assign rise = i_Switch & ~prev_q;
  assign fall = ~i_Switch & prev_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= StIdle;
      prev_q    <= 1'b0;
      count_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      prev_q    <= i_Switch;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StHeld;
            count_q <= '0;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end
        end
        StHeld: begin
          // A release on the terminal-count edge wins: click, never long.
          if (fall) begin
            state_q   <= StIdle;
            release_q <= 1'b1;
            click_q   <= 1'b1;
            held_q    <= 1'b0;
          end else if (count_q == LongLast) begin
            state_q <= StRepeat;
            count_q <= '0;
            long_q  <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        StRepeat: begin
          if (fall) begin
            state_q   <= StIdle;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else if (count_q == RepeatLast) begin
            count_q  <= '0;
            repeat_q <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Click   = click_q;
  assign o_Long    = long_q;
  assign o_Repeat  = repeat_q;
  assign o_Held    = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with LONG_LIMIT=8, REPEAT_PERIOD=4.
// Stimulus pushes hand-computed {cycle, events, held} entries; a negedge monitor pops and compares.
module tb_button_event_decoder;

  localparam logic [4:0] EvPress   = 5'b10000;
  localparam logic [4:0] EvRelClk  = 5'b01100;
  localparam logic [4:0] EvRelease = 5'b01000;
  localparam logic [4:0] EvLong    = 5'b00010;
  localparam logic [4:0] EvRepeat  = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
    logic       held;
  } exp_t;

  logic clk, rst, sw;
  logic press, release_o, click, long_o, repeat_o, held;
  int   cyc;
  int   n_vec;
  int   n_fail;
  exp_t exp_q[$];

  button_event_decoder #(
    .LONG_LIMIT   (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Switch (sw),
    .o_Press  (press),
    .o_Release(release_o),
    .o_Click  (click),
    .o_Long   (long_o),
    .o_Repeat (repeat_o),
    .o_Held   (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with any event pulse must match the next expected entry.
  always @(negedge clk) begin
    logic [4:0] ev;
    exp_t       e;
    ev = {press, release_o, click, long_o, repeat_o};
    if (!rst && ev != 5'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d got ev=%b held=%b, required none", cyc, ev, held);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.ev != ev || e.held != held) begin
          n_fail++;
          $display("FAIL event cyc=%0d ev=%b held=%b, required cyc=%0d ev=%b held=%b",
                   cyc, ev, held, e.cyc, e.ev, e.held);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int c, input logic [4:0] ev, input logic h);
    exp_t e;
    e.cyc  = c;
    e.ev   = ev;
    e.held = h;
    exp_q.push_back(e);
  endtask

  task automatic check_quiet(input string name);
    n_vec++;
    if ({press, release_o, click, long_o, repeat_o, held} != 6'b0) begin
      n_fail++;
      $display("FAIL %s outputs=%b, required 000000", name,
               {press, release_o, click, long_o, repeat_o, held});
    end
  endtask

  int c;
  int d;

  initial begin
    cyc    = 0;
    n_vec  = 0;
    n_fail = 0;
    sw     = 1'b0;
    rst    = 1'b1;
    #1;
    check_quiet("reset_state");
    step(3);
    rst = 1'b0;
    step(2);

    // Short hold of 3: press, then release+click, no long.
    c = cyc;
    expect_ev(c + 1, EvPress, 1'b1);
    expect_ev(c + 4, EvRelClk, 1'b0);
    sw = 1'b1; step(3); sw = 1'b0; step(4);

    // Hold of 21: long at +8 after press, repeats at +12/+16/+20, plain release.
    c = cyc;
    expect_ev(c + 1,  EvPress,   1'b1);
    expect_ev(c + 9,  EvLong,    1'b1);
    expect_ev(c + 13, EvRepeat,  1'b1);
    expect_ev(c + 17, EvRepeat,  1'b1);
    expect_ev(c + 21, EvRepeat,  1'b1);
    expect_ev(c + 22, EvRelease, 1'b0);
    sw = 1'b1; step(21); sw = 1'b0; step(4);

    // Release exactly on the long terminal-count edge: click, never long.
    c = cyc;
    expect_ev(c + 1, EvPress,  1'b1);
    expect_ev(c + 9, EvRelClk, 1'b0);
    sw = 1'b1; step(8); sw = 1'b0; step(4);

    // Release on the first repeat terminal edge: release only, no repeat.
    c = cyc;
    expect_ev(c + 1,  EvPress,   1'b1);
    expect_ev(c + 9,  EvLong,    1'b1);
    expect_ev(c + 13, EvRelease, 1'b0);
    sw = 1'b1; step(12); sw = 1'b0; step(4);

    // Reset mid-press clears outputs at once; held switch re-presses after reset.
    c = cyc;
    expect_ev(c + 1, EvPress, 1'b1);
    sw = 1'b1; step(5);
    rst = 1'b1;
    #1;
    check_quiet("async_reset_mid_hold");
    step(2);
    check_quiet("reset_held");
    rst = 1'b0;
    d = cyc;
    expect_ev(d + 1, EvPress,  1'b1);
    expect_ev(d + 4, EvRelClk, 1'b0);
    step(3); sw = 1'b0; step(4);

    // Back-to-back one-cycle pulses.
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      expect_ev(c + 1 + 2 * i, EvPress,  1'b1);
      expect_ev(c + 2 + 2 * i, EvRelClk, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      sw = 1'b1; step(1); sw = 1'b0; step(1);
    end
    step(10);

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL missing_event got none, required cyc=%0d ev=%b held=%b", e.cyc, e.ev, e.held);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
